taxi_fare_core: RTL

TAXI_FARE_CORE -- requirements
Module: taxi_fare_core

---
 rtl/fare_pkg.sv | 26 ++
 rtl/taxi_fare_core_if.sv | 35 +++
 rtl/key_debounce.sv | 39 +++
 rtl/taxi_fare_core.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fare_pkg.sv
// Shared constants for the taxi meter: FSM state encoding, default tariff and
// timing values, and the bundle of debounced key flags.
package fare_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam int DEF_CLK_FREQ      = 50_000_000;
  localparam int DEF_DEBOUNCE_CYC  = 1_000_000;
  localparam int DEF_PRICE_W       = 20;
  localparam int DEF_KM_W          = 16;
  localparam int DEF_BASE_KM       = 3;
  localparam int DEF_START_FARE    = 8;
  localparam int DEF_DAY_KM_RATE   = 2;
  localparam int DEF_NIGHT_KM_RATE = 3;
  localparam int DEF_WAIT_RATE     = 1;

  typedef struct packed {
    logic pulse;
    logic stat;
    logic trip;
  } key_flags_t;

endpackage

// File: rtl/taxi_fare_core_if.sv
// Key inputs and meter/display outputs of the taxi fare core, bundled as one
// interface; the core sits on the slave side.
interface taxi_fare_core_if #(
  parameter int PRICE_W = fare_pkg::DEF_PRICE_W,
  parameter int KM_W    = fare_pkg::DEF_KM_W
);

  logic               pulse_port;
  logic               stat_port;
  logic               trip_port;
  logic               night_mode;
  logic [PRICE_W-1:0] price;
  logic [KM_W-1:0]    km_num;
  logic [3:0]         hm_num;
  logic [15:0]        wait_min;
  logic [5:0]         wait_sec;
  logic [1:0]         state;
  logic               trip_done;
  logic               seg_en;
  logic [5:0]         point;
  logic               sign;

  modport slave (
    input  pulse_port, stat_port, trip_port, night_mode,
    output price, km_num, hm_num, wait_min, wait_sec, state,
           trip_done, seg_en, point, sign
  );

  modport master (
    output pulse_port, stat_port, trip_port, night_mode,
    input  price, km_num, hm_num, wait_min, wait_sec, state,
           trip_done, seg_en, point, sign
  );

endinterface

// File: rtl/key_debounce.sv
// Active-low key debouncer: synchronises the key, then raises a single 1-cycle
// flag once it has been low for DEBOUNCE_CYC consecutive cycles.
module key_debounce #(
  parameter int DEBOUNCE_CYC = fare_pkg::DEF_DEBOUNCE_CYC
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic key_flag
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  // The counter parks at CNT_MAX after firing, so a held key cannot re-flag
  // until a high cycle clears it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      key_flag <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      if (sync_q[1]) begin
        cnt_q    <= '0;
        key_flag <= 1'b0;
      end else if (cnt_q < CNT_MAX) begin
        cnt_q    <= cnt_q + 1'b1;
        key_flag <= (cnt_q == CNT_MAX - 1'b1);
      end else begin
        key_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/taxi_fare_core.sv
// Taxi meter core: debounced keys drive an IDLE/RUN/WAIT/HOLD trip FSM, distance
// and wait-time counters, and a registered, saturating fare.
module taxi_fare_core import fare_pkg::*; #(
  parameter int CLK_FREQ      = DEF_CLK_FREQ,
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int PRICE_W       = DEF_PRICE_W,
  parameter int KM_W          = DEF_KM_W,
  parameter int BASE_KM       = DEF_BASE_KM,
  parameter int START_FARE    = DEF_START_FARE,
  parameter int DAY_KM_RATE   = DEF_DAY_KM_RATE,
  parameter int NIGHT_KM_RATE = DEF_NIGHT_KM_RATE,
  parameter int WAIT_RATE     = DEF_WAIT_RATE
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  taxi_fare_core_if.slave  bus
);

  localparam int               SEC_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [SEC_W-1:0] TICK_MAX = SEC_W'(CLK_FREQ - 1);
  localparam int               ACC_W    = (PRICE_W + 8 > 64) ? PRICE_W + 8 : 64;

  key_flags_t       flags;
  logic [1:0]       state_q, state_d;
  logic             start_trip, end_trip;
  logic             night_q, trip_done_q, seg_en_q;
  logic [KM_W-1:0]  km_q;
  logic [3:0]       hm_q;
  logic [15:0]      min_q;
  logic [5:0]       sec_q;
  logic [SEC_W-1:0] tick_q;
  logic [KM_W:0]    ckm;
  logic [16:0]      cmin;
  logic [ACC_W-1:0] rate, fare_sum;
  logic [PRICE_W-1:0] price_p1;

  function automatic logic [KM_W:0] charged_km(input logic [KM_W-1:0] km,
                                               input logic [3:0] hm);
    logic [KM_W:0] base;
    base = (KM_W + 1)'(BASE_KM);
    if (({1'b0, km} < base) || (({1'b0, km} == base) && (hm == 4'd0)))
      charged_km = '0;
    else
      charged_km = {1'b0, km} - base + {{KM_W{1'b0}}, (hm != 4'd0)};
  endfunction

  function automatic logic [PRICE_W-1:0] sat_price(input logic [ACC_W-1:0] sum);
    if (|sum[ACC_W-1:PRICE_W]) sat_price = '1;
    else                       sat_price = sum[PRICE_W-1:0];
  endfunction

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pulse_db (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(bus.pulse_port), .key_flag(flags.pulse)
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_stat_db (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(bus.stat_port), .key_flag(flags.stat)
  );
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_trip_db (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(bus.trip_port), .key_flag(flags.trip)
  );

  assign start_trip = flags.trip && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
  assign end_trip   = flags.trip && ((state_q == ST_RUN)  || (state_q == ST_WAIT));

  // Trip key is checked first so a simultaneous stat flag is simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HOLD: if (flags.trip) state_d = ST_RUN;
      ST_RUN:  if (flags.trip) state_d = ST_HOLD; else if (flags.stat) state_d = ST_WAIT;
      ST_WAIT: if (flags.trip) state_d = ST_HOLD; else if (flags.stat) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      trip_done_q <= 1'b0;
      seg_en_q    <= 1'b0;
      night_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      trip_done_q <= end_trip;
      seg_en_q    <= 1'b1;
      if (start_trip) night_q <= bus.night_mode;
    end
  end

  // Distance: pulses count in RUN, including the cycle RUN is being left.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      km_q <= '0;
      hm_q <= '0;
    end else if (start_trip) begin
      km_q <= '0;
      hm_q <= '0;
    end else if ((state_q == ST_RUN) && flags.pulse) begin
      if (hm_q == 4'd9) begin
        if (km_q != '1) begin
          km_q <= km_q + 1'b1;
          hm_q <= '0;
        end
      end else begin
        hm_q <= hm_q + 1'b1;
      end
    end
  end

  // Wait time: seconds timebase runs only in WAIT; full counter holds at FFFF:59.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
    end else if (start_trip) begin
      tick_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
    end else if (state_q == ST_WAIT) begin
      if (tick_q == TICK_MAX) begin
        tick_q <= '0;
        if (sec_q == 6'd59) begin
          if (min_q != 16'hFFFF) begin
            min_q <= min_q + 1'b1;
            sec_q <= '0;
          end
        end else begin
          sec_q <= sec_q + 1'b1;
        end
      end else begin
        tick_q <= tick_q + 1'b1;
      end
    end
  end

  always_comb begin
    ckm      = charged_km(km_q, hm_q);
    cmin     = {1'b0, min_q} + {16'd0, (sec_q != 6'd0)};
    rate     = night_q ? ACC_W'(NIGHT_KM_RATE) : ACC_W'(DAY_KM_RATE);
    fare_sum = ACC_W'(START_FARE) + rate * ACC_W'(ckm) + ACC_W'(WAIT_RATE) * ACC_W'(cmin);
  end

  // Stage p1: registered fare, one cycle behind the counters.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)               price_p1 <= '0;
    else if (state_q == ST_IDLE)  price_p1 <= '0;
    else                          price_p1 <= sat_price(fare_sum);
  end

  assign bus.price     = price_p1;
  assign bus.km_num    = km_q;
  assign bus.hm_num    = hm_q;
  assign bus.wait_min  = min_q;
  assign bus.wait_sec  = sec_q;
  assign bus.state     = state_q;
  assign bus.trip_done = trip_done_q;
  assign bus.seg_en    = seg_en_q;
  assign bus.point     = '0;
  assign bus.sign      = 1'b0;

endmodule
